// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter.
//
// Merges single-cycle pipeline (ALU) writebacks with buffered results from a
// multi-cycle unit (MDU). The ALU always wins the write port. MDU results wait
// in a DEPTH-entry FIFO and drain in cycles where the ALU does not write.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   alu_wen_i      pipeline writeback request (no backpressure)
//   alu_waddr_i    pipeline destination register (5 bits)
//   alu_wdata_i    pipeline result (64 bits)
//   mdu_valid_i    MDU result valid
//   mdu_ready_o    FIFO can accept an MDU result
//   mdu_waddr_i    MDU destination register (5 bits)
//   mdu_wdata_i    MDU result (64 bits)
//   reg_wen_o      register file write enable (registered)
//   reg_waddr_o    register file write address (registered)
//   reg_wdata_o    register file write data (registered)
//   busy_o         per-register pending-write scoreboard for decode
//   alu_stall_o    asks the pipeline to hold off ALU writes so the FIFO drains
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_wen_i,
  input  logic [4:0]  alu_waddr_i,
  input  logic [63:0] alu_wdata_i,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_waddr_i,
  input  logic [63:0] mdu_wdata_i,
  output logic        reg_wen_o,
  output logic [4:0]  reg_waddr_o,
  output logic [63:0] reg_wdata_o,
  output logic [31:0] busy_o,
  output logic        alu_stall_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] STV_ONE   = SW'(1);
  localparam logic [SW-1:0] STV_LIMIT = SW'(STARVE_LIMIT);

  // FIFO storage; a slot's valid bit is set only while it is occupied and
  // not overwritten by a younger ALU write to the same register.
  logic        val_r  [DEPTH];
  logic [4:0]  addr_r [DEPTH];
  logic [63:0] data_r [DEPTH];

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [SW-1:0] starve_r;
  logic [31:0]   busy_s;

  logic full_s;
  logic empty_s;
  logic alu_take_s;
  logic push_s;
  logic pop_s;
  logic head_val_s;

  assign full_s      = (count_r == CNT_FULL);
  assign empty_s     = (count_r == {CW{1'b0}});
  // Ready looks at registered occupancy only, so a full FIFO stays not-ready
  // even in a cycle where it pops.
  assign mdu_ready_o = !full_s && !rst;

  assign alu_take_s  = alu_wen_i && (alu_waddr_i != 5'd0);
  // Writes to x0 complete the handshake but are dropped here.
  assign push_s      = mdu_valid_i && mdu_ready_o && (mdu_waddr_i != 5'd0);
  // count_r excludes this cycle's push, so a fresh entry cannot pop yet.
  assign pop_s       = !alu_take_s && !empty_s;
  assign head_val_s  = val_r[rd_ptr_r];

  assign alu_stall_o = (starve_r == STV_LIMIT);

  // Next occupancy from push/pop of this cycle.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO control state: pointers, occupancy and valid bits (WAW kill, pop, push).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        val_r[i] <= 1'b0;
      end
    end else begin
      // Younger ALU write supersedes queued results for the same register.
      // The push below comes later, so an entry pushed this cycle survives.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_take_s && val_r[i] && (addr_r[i] == alu_waddr_i)) begin
          val_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        val_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r        <= rd_ptr_r + PTR_ONE;
      end
      if (push_s) begin
        val_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // FIFO payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_r[wr_ptr_r] <= mdu_waddr_i;
      data_r[wr_ptr_r] <= mdu_wdata_i;
    end
  end

  // Write-port register: ALU first, then FIFO head, else idle with held address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wen_o   <= 1'b0;
      reg_waddr_o <= 5'd0;
      reg_wdata_o <= 64'd0;
    end else if (alu_take_s) begin
      reg_wen_o   <= 1'b1;
      reg_waddr_o <= alu_waddr_i;
      reg_wdata_o <= alu_wdata_i;
    end else if (pop_s) begin
      // A killed head still consumes its slot but produces no write.
      reg_wen_o <= head_val_s;
      if (head_val_s) begin
        reg_waddr_o <= addr_r[rd_ptr_r];
        reg_wdata_o <= data_r[rd_ptr_r];
      end
    end else begin
      reg_wen_o <= 1'b0;
    end
  end

  // Starvation counter: counts ALU-won cycles while MDU results wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_r <= {SW{1'b0}};
    end else if (empty_s || pop_s) begin
      starve_r <= {SW{1'b0}};
    end else if (alu_take_s && (starve_r != STV_LIMIT)) begin
      starve_r <= starve_r + STV_ONE;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Pending-write scoreboard built from the registered valid/address bits.
  always_comb begin
    busy_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_s = busy_s | ({31'd0, val_r[i]} << addr_r[i]);
    end
  end

  assign busy_o = busy_s & ~32'd1;

endmodule
